// File: rtl/hybrid_pwm_sd_multi.sv
// N-channel hybrid PWM / second-order error-feedback sigma-delta DAC.
// Define SD_DITHER_EN to add per-channel LFSR dither ahead of the quantiser.
module hybrid_pwm_sd_multi #(
  parameter int CHANNELS   = 2,
  parameter int DATA_WIDTH = 16,
  parameter int PWM_BITS   = 5,
  parameter int SIGNED_IN  = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [CHANNELS*DATA_WIDTH-1:0] d,
  input  logic                           d_stb,
  input  logic                           mute,
  output logic [CHANNELS-1:0]            q,
  output logic [CHANNELS-1:0]            clip,
  output logic                           period_stb
);

  localparam int SHIFT = DATA_WIDTH - PWM_BITS;
  localparam int VW    = DATA_WIDTH + 4;
  localparam logic [PWM_BITS-1:0]   CNT_LAST = '1;
  localparam logic [DATA_WIDTH-1:0] MID      = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [VW-1:0]  Q_MAX    = VW'((1 << PWM_BITS) - 1);
  localparam logic signed [VW-1:0]  E_LIM    = VW'(1 << (SHIFT + 1));

  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic                  period_stb_q, period_stb_d;
  logic [DATA_WIDTH-1:0] hold_q [CHANNELS];
  logic [DATA_WIDTH-1:0] hold_d [CHANNELS];
  logic signed [VW-1:0]  e1_q [CHANNELS];
  logic signed [VW-1:0]  e1_d [CHANNELS];
  logic signed [VW-1:0]  e2_q [CHANNELS];
  logic signed [VW-1:0]  e2_d [CHANNELS];
  logic [PWM_BITS-1:0]   duty_q [CHANNELS];
  logic [PWM_BITS-1:0]   duty_d [CHANNELS];
  logic [CHANNELS-1:0]   q_q, q_d, clip_q, clip_d;

  logic                  update;
  logic [DATA_WIDTH-1:0] x    [CHANNELS];
  logic signed [VW-1:0]  dith [CHANNELS];
  logic signed [VW-1:0]  v    [CHANNELS];
  logic signed [VW-1:0]  qv   [CHANNELS];
  logic signed [VW-1:0]  e    [CHANNELS];
  logic [CHANNELS-1:0]   sat;

  assign update = (pwm_cnt_q == CNT_LAST);

`ifdef SD_DITHER_EN
  localparam logic signed [VW-1:0] DITH_OFS = VW'(1 << (SHIFT - 2));

  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] lfsr_rot [CHANNELS];

  always_comb begin
    lfsr_d = lfsr_q;
    if (update) lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    // Each channel sees a rotated copy so the dither is decorrelated across pins.
    for (int n = 0; n < CHANNELS; n++) begin
      lfsr_rot[n] = (lfsr_q << n) | (lfsr_q >> (16 - n));
      dith[n]     = $signed(VW'(lfsr_rot[n][SHIFT-2:0])) - DITH_OFS;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= 16'hACE1;
    else          lfsr_q <= lfsr_d;
  end
`else
  always_comb begin
    for (int n = 0; n < CHANNELS; n++) dith[n] = '0;
  end
`endif

  // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned and infers a latch.
  always_comb begin
    pwm_cnt_d    = pwm_cnt_q + 1'b1;
    period_stb_d = (pwm_cnt_d == CNT_LAST);
    for (int n = 0; n < CHANNELS; n++) begin
      hold_d[n] = hold_q[n];
      if (d_stb) begin
        hold_d[n] = d[n*DATA_WIDTH +: DATA_WIDTH];
        if (SIGNED_IN != 0) hold_d[n][DATA_WIDTH-1] = ~d[n*DATA_WIDTH + DATA_WIDTH - 1];
      end

      x[n]   = mute ? MID : hold_q[n];
      v[n]   = $signed({4'b0000, x[n]}) + (e1_q[n] <<< 1) - e2_q[n] + dith[n];
      qv[n]  = v[n] >>> SHIFT;
      sat[n] = 1'b0;
      if (v[n] < 0) begin
        qv[n]  = '0;
        sat[n] = 1'b1;
      end else if (qv[n] > Q_MAX) begin
        qv[n]  = Q_MAX;
        sat[n] = 1'b1;
      end

      // Bounding the residual keeps a long clip from winding up the loop.
      e[n] = v[n] - (qv[n] <<< SHIFT);
      if (e[n] > E_LIM)       e[n] = E_LIM;
      else if (e[n] < -E_LIM) e[n] = -E_LIM;

      e1_d[n]   = e1_q[n];
      e2_d[n]   = e2_q[n];
      duty_d[n] = duty_q[n];
      clip_d[n] = 1'b0;
      if (update) begin
        e2_d[n]   = e1_q[n];
        e1_d[n]   = e[n];
        duty_d[n] = qv[n][PWM_BITS-1:0];
        clip_d[n] = sat[n];
      end

      // Compare next-state values so q lines up with the counter it is registered against.
      q_d[n] = (pwm_cnt_d < duty_d[n]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt_q    <= '0;
      period_stb_q <= 1'b0;
      q_q          <= '0;
      clip_q       <= '0;
      // NOTE: these per-channel arrays are plain flops, not a RAM, so resetting them is cheap and required.
      for (int n = 0; n < CHANNELS; n++) begin
        hold_q[n] <= MID;
        e1_q[n]   <= '0;
        e2_q[n]   <= '0;
        duty_q[n] <= '0;
      end
    end else begin
      pwm_cnt_q    <= pwm_cnt_d;
      period_stb_q <= period_stb_d;
      q_q          <= q_d;
      clip_q       <= clip_d;
      for (int n = 0; n < CHANNELS; n++) begin
        hold_q[n] <= hold_d[n];
        e1_q[n]   <= e1_d[n];
        e2_q[n]   <= e2_d[n];
        duty_q[n] <= duty_d[n];
      end
    end
  end

  assign q          = q_q;
  assign clip       = clip_q;
  assign period_stb = period_stb_q;

endmodule

// File: tb/tb_hybrid_pwm_sd_multi.sv
// Self-checking bench for hybrid_pwm_sd_multi: a default stereo instance and a 4-channel
// unsigned instance, both compared every cycle against an integer reference model.
module tb_hybrid_pwm_sd_multi;

  localparam int CH_A = 2, DW_A = 16, PB_A = 5;
  localparam int CH_B = 4, DW_B = 12, PB_B = 4;

  logic                 clk     = 1'b0;
  logic                 reset_n = 1'b0;

  logic [CH_A*DW_A-1:0] d_a     = '0;
  logic                 d_stb_a = 1'b0;
  logic                 mute_a  = 1'b0;
  logic [CH_A-1:0]      q_a, clip_a;
  logic                 period_stb_a;

  logic [CH_B*DW_B-1:0] d_b     = '0;
  logic                 d_stb_b = 1'b0;
  logic                 mute_b  = 1'b0;
  logic [CH_B-1:0]      q_b, clip_b;
  logic                 period_stb_b;

  always #5 clk = ~clk;

  hybrid_pwm_sd_multi dut_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .d          (d_a),
    .d_stb      (d_stb_a),
    .mute       (mute_a),
    .q          (q_a),
    .clip       (clip_a),
    .period_stb (period_stb_a)
  );

  hybrid_pwm_sd_multi #(
    .CHANNELS   (CH_B),
    .DATA_WIDTH (DW_B),
    .PWM_BITS   (PB_B),
    .SIGNED_IN  (0)
  ) dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .d          (d_b),
    .d_stb      (d_stb_b),
    .mute       (mute_b),
    .q          (q_b),
    .clip       (clip_b),
    .period_stb (period_stb_b)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: index 0 = dut_a, 1 = dut_b.
  int p_ch [2] = '{CH_A, CH_B};
  int p_dw [2] = '{DW_A, DW_B};
  int p_pb [2] = '{PB_A, PB_B};
  int p_sg [2] = '{1, 0};
  int m_cnt  [2];
  int m_hold [2][8];
  int m_e1   [2][8];
  int m_e2   [2][8];
  int m_duty [2][8];
  bit m_clip [2][8];

  int hi_a [CH_A];
  int cl_a [CH_A];
  int hi_b [CH_B];
  int cl_b [CH_B];

  typedef struct {
    logic [15:0] d0;
    logic [15:0] d1;
    logic        mute;
    int          avg0;
    int          avg1;
    int          clips0;
    int          clips1;
  } vec_t;

  vec_t vecs [5];
  int   exp_avg_b [CH_B] = '{0, 8, 12, 15};
  int   exp_cl_b  [CH_B] = '{0, 0, 0, 64};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act > exp + tol || act < exp - tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (+/-%0d)", name, act, exp, tol);
    end
  endtask

  // One modulator step from the arithmetic rules: quantise, clamp, residual, bound.
  function automatic void mod_step(input int x, input int s, input int pb, input int e1,
                                   input int e2, output int qv, output int e_new, output bit sat);
    int v, lim, qmax;
    v    = x + 2 * e1 - e2;
    qmax = (1 << pb) - 1;
    lim  = 1 << (s + 1);
    sat  = 1'b0;
    if (v < 0) begin
      qv  = 0;
      sat = 1'b1;
    end else begin
      qv = v / (1 << s);
      if (qv > qmax) begin
        qv  = qmax;
        sat = 1'b1;
      end
    end
    e_new = v - qv * (1 << s);
    if (e_new > lim)       e_new = lim;
    else if (e_new < -lim) e_new = -lim;
  endfunction

  task automatic model_reset(input int i);
    m_cnt[i] = 0;
    for (int n = 0; n < 8; n++) begin
      m_hold[i][n] = 1 << (p_dw[i] - 1);
      m_e1[i][n]   = 0;
      m_e2[i][n]   = 0;
      m_duty[i][n] = 0;
      m_clip[i][n] = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input logic rst, input logic stb, input logic mt,
                            input longint unsigned dv);
    int per, s, mid, x, qv, en;
    bit sat;
    longint unsigned samp;
    if (!rst) begin
      model_reset(i);
      return;
    end
    per = 1 << p_pb[i];
    s   = p_dw[i] - p_pb[i];
    mid = 1 << (p_dw[i] - 1);
    for (int n = 0; n < p_ch[i]; n++) begin
      m_clip[i][n] = 1'b0;
      if (m_cnt[i] == per - 1) begin
        x = mt ? mid : m_hold[i][n];
        mod_step(x, s, p_pb[i], m_e1[i][n], m_e2[i][n], qv, en, sat);
        m_e2[i][n]   = m_e1[i][n];
        m_e1[i][n]   = en;
        m_duty[i][n] = qv;
        m_clip[i][n] = sat;
      end
      if (stb) begin
        samp = (dv >> (n * p_dw[i])) & ((64'd1 << p_dw[i]) - 64'd1);
        m_hold[i][n] = int'(samp);
        if (p_sg[i] != 0) m_hold[i][n] = m_hold[i][n] ^ mid;
      end
    end
    m_cnt[i] = (m_cnt[i] + 1) % per;
  endtask

  task automatic compare_all();
    logic [7:0] eq_a, ec_a, eq_b, ec_b;
    eq_a = '0; ec_a = '0; eq_b = '0; ec_b = '0;
    for (int n = 0; n < CH_A; n++) begin
      eq_a[n] = (m_cnt[0] < m_duty[0][n]);
      ec_a[n] = m_clip[0][n];
    end
    for (int n = 0; n < CH_B; n++) begin
      eq_b[n] = (m_cnt[1] < m_duty[1][n]);
      ec_b[n] = m_clip[1][n];
    end
    check("q_a",    64'(q_a),          64'(eq_a[CH_A-1:0]));
    check("clip_a", 64'(clip_a),       64'(ec_a[CH_A-1:0]));
    check("pstb_a", 64'(period_stb_a), 64'(m_cnt[0] == (1 << PB_A) - 1));
    check("q_b",    64'(q_b),          64'(eq_b[CH_B-1:0]));
    check("clip_b", 64'(clip_b),       64'(ec_b[CH_B-1:0]));
    check("pstb_b", 64'(period_stb_b), 64'(m_cnt[1] == (1 << PB_B) - 1));
  endtask

  task automatic tick();
    logic r, sa, ma, sb, mb;
    longint unsigned da, db;
    r  = reset_n;
    sa = d_stb_a; ma = mute_a; da = 64'(d_a);
    sb = d_stb_b; mb = mute_b; db = 64'(d_b);
    @(posedge clk);
    model_step(0, r, sa, ma, da);
    model_step(1, r, sb, mb, db);
    #1;
    compare_all();
  endtask

  // Counts q-high cycles and clip pulses; any pending capture strobe is dropped after one cycle.
  task automatic measure(input int n_ticks);
    for (int n = 0; n < CH_A; n++) begin hi_a[n] = 0; cl_a[n] = 0; end
    for (int n = 0; n < CH_B; n++) begin hi_b[n] = 0; cl_b[n] = 0; end
    for (int k = 0; k < n_ticks; k++) begin
      tick();
      if (k == 0) begin
        d_stb_a = 1'b0;
        d_stb_b = 1'b0;
      end
      for (int n = 0; n < CH_A; n++) begin
        hi_a[n] += int'(q_a[n]);
        cl_a[n] += int'(clip_a[n]);
      end
      for (int n = 0; n < CH_B; n++) begin
        hi_b[n] += int'(q_b[n]);
        cl_b[n] += int'(clip_b[n]);
      end
    end
  endtask

  task automatic wait_pstb_a();
    int k;
    k = 0;
    while (period_stb_a !== 1'b1 && k < 64) begin
      tick();
      k++;
    end
    check("pstb_a_reached", 64'(period_stb_a), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int first_a, first_b, sum_cl;

    vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16, 16, 0,  0};
    vecs[1] = '{16'h8000, 16'h7FFF, 1'b0, 0,  31, 0,  64};
    vecs[2] = '{16'h4000, 16'hC000, 1'b0, 24, 8,  0,  0};
    vecs[3] = '{16'h2000, 16'hE000, 1'b0, 20, 12, 0,  0};
    vecs[4] = '{16'h7FFF, 16'h8000, 1'b1, 16, 16, 0,  0};

    model_reset(0);
    model_reset(1);

    // Reset held with strobes toggling: outputs stay low.
    d_a = {2{16'h1234}};
    d_b = {4{12'h234}};
    for (int k = 0; k < 5; k++) begin
      d_stb_a = (k % 2 == 1);
      d_stb_b = (k % 2 == 1);
      tick();
      check("rst_q_a",    64'(q_a),          64'd0);
      check("rst_clip_a", 64'(clip_a),       64'd0);
      check("rst_pstb_a", 64'(period_stb_a), 64'd0);
    end
    d_stb_a = 1'b0;
    d_stb_b = 1'b0;
    reset_n = 1'b1;
    first_a = -1;
    first_b = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (period_stb_a === 1'b1 && first_a < 0) first_a = k;
      if (period_stb_b === 1'b1 && first_b < 0) first_b = k;
    end
    check("first_pstb_a", 64'(first_a), 64'd31);
    check("first_pstb_b", 64'(first_b), 64'd15);

    // Four unsigned channels at distinct levels.
    d_b = {12'hFFF, 12'hC00, 12'h800, 12'h000};
    d_stb_b = 1'b1;
    tick();
    d_stb_b = 1'b0;
    repeat (128) tick();
    measure(64 * 16);
    for (int n = 0; n < CH_B; n++) begin
      check_near($sformatf("b_avg_ch%0d", n), (hi_b[n] + 32) / 64, exp_avg_b[n], 1);
      check($sformatf("b_clips_ch%0d", n), 64'(cl_b[n]), 64'(exp_cl_b[n]));
    end

    // Steady-state table on the stereo instance.
    for (int vi = 0; vi < 5; vi++) begin
      d_a     = {vecs[vi].d1, vecs[vi].d0};
      mute_a  = vecs[vi].mute;
      d_stb_a = 1'b1;
      tick();
      d_stb_a = 1'b0;
      repeat (4 * 32) tick();
      measure(64 * 32);
      check_near($sformatf("vec%0d_avg0", vi), (hi_a[0] + 32) / 64, vecs[vi].avg0, 1);
      check_near($sformatf("vec%0d_avg1", vi), (hi_a[1] + 32) / 64, vecs[vi].avg1, 1);
      check($sformatf("vec%0d_clips0", vi), 64'(cl_a[0]), 64'(vecs[vi].clips0));
      check($sformatf("vec%0d_clips1", vi), 64'(cl_a[1]), 64'(vecs[vi].clips1));
    end
    mute_a = 1'b0;

    // Strobe gating and capture on the update edge.
    d_a     = '0;
    d_stb_a = 1'b1;
    tick();
    d_stb_a = 1'b0;
    repeat (4 * 32) tick();
    d_a = {2{16'h4000}};
    repeat (200) tick();
    wait_pstb_a();
    measure(32);
    check("gate_no_stb_duty", 64'(hi_a[0]), 64'd16);
    d_stb_a = 1'b1;
    measure(32);
    check("gate_stb_edge_old", 64'(hi_a[0]), 64'd16);
    measure(32);
    check("gate_stb_edge_new", 64'(hi_a[0]), 64'd24);
    measure(64 * 32);
    check_near("gate_avg", (hi_a[0] + 32) / 64, 24, 1);

    // Mute from saturation, then release.
    d_a     = {2{16'h7FFF}};
    d_stb_a = 1'b1;
    tick();
    d_stb_a = 1'b0;
    repeat (4 * 32) tick();
    wait_pstb_a();
    mute_a = 1'b1;
    sum_cl = 0;
    measure(32);
    sum_cl += cl_a[0];
    measure(32);
    sum_cl += cl_a[0];
    measure(32);
    sum_cl += cl_a[0];
    check("mute_duty", 64'(hi_a[0]), 64'd16);
    check("mute_clips", 64'(sum_cl), 64'd0);
    mute_a = 1'b0;
    measure(32);
    measure(32);
    measure(32);
    check("unmute_duty", 64'(hi_a[0]), 64'd31);
    check("unmute_clip", 64'(cl_a[0]), 64'd1);

    // Random traffic with a reset dropped mid-period.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) d_a = $urandom();
      if ($urandom_range(0, 15) == 0) d_b = 48'({$urandom(), $urandom()});
      d_stb_a = ($urandom_range(0, 7) == 0);
      d_stb_b = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) mute_a = ~mute_a;
      if ($urandom_range(0, 99) == 0) mute_b = ~mute_b;
      tick();
      if (k == 1500) begin
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_q_a",    64'(q_a),          64'd0);
        check("midrst_clip_a", 64'(clip_a),       64'd0);
        check("midrst_pstb_a", 64'(period_stb_a), 64'd0);
        check("midrst_q_b",    64'(q_b),          64'd0);
        model_reset(0);
        model_reset(1);
        repeat (3) tick();
        reset_n = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
